// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH+1 cycles per result with start/done.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting x - y.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  xr_q, xr_d;
    logic [WIDTH-1:0]  yr_q, yr_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cr_q, cr_d;
    logic              c_q, c_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              sum_bit;
    logic              carry_nxt;
    logic [WIDTH-1:0]  sum_shift;
    logic [WIDTH-1:0]  y_load;
    logic              c_load;

    always_comb begin
        state_d   = state_q;
        xr_d      = xr_q;
        yr_d      = yr_q;
        acc_d     = acc_q;
        s_d       = s_q;
        cr_d      = cr_q;
        c_d       = c_q;
        cnt_d     = cnt_q;

        sum_bit   = xr_q[0] ^ yr_q[0] ^ cr_q;
        carry_nxt = (xr_q[0] & yr_q[0]) | (xr_q[0] & cr_q) | (yr_q[0] & cr_q);
        // Shift right with the new bit entering the MSB; works for WIDTH=1 too.
        sum_shift = acc_q >> 1;
        sum_shift[WIDTH-1] = sum_bit;

        y_load = y;
        c_load = z;
`ifdef SERIAL_ADDER_SUB_EN
        // Two's-complement subtract: x + ~y + 1.
        if (sub) begin
            y_load = ~y;
            c_load = 1'b1;
        end
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    xr_d    = x;
                    yr_d    = y_load;
                    cr_d    = c_load;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                xr_d  = xr_q >> 1;
                yr_d  = yr_q >> 1;
                cr_d  = carry_nxt;
                acc_d = sum_shift;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    s_d     = sum_shift;
                    c_d     = carry_nxt;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cr_q    <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cr_q    <= cr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign s    = s_q;
    assign c    = c_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder built around a single full-adder cell.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Uses a start/done handshake and returns a WIDTH-bit sum plus carry-out.
- Area-cheap arithmetic unit for datapaths where WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- x  input  WIDTH  operand A; captured on accepted start.
- y  input  WIDTH  operand B; captured on accepted start.
- z  input  1  carry-in; captured on accepted start.
- busy  output  1  high while a bit-serial operation is running.
- done  output  1  one-cycle pulse; s/c valid from this cycle on.
- s  output  WIDTH  sum register.
- c  output  1  carry-out register.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, s=0, c=0, bit counter=0, internal shift registers=0.
  - Reset overrides everything, including an operation in progress; the aborted result is discarded.
- States:
  - IDLE: busy=0. Accepted start loads the operands and moves to RUN.
  - RUN: busy=1. Processes one bit per clock.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept rule: start=1 at an edge with state IDLE or DONE loads the x and y shift registers, loads the carry flop with z, clears the counter and moves to RUN.
  - start while in RUN is ignored; the operands are not re-sampled.
- RUN, each edge:
  - bit = xr[0] ^ yr[0] ^ cr
  - cr <= (xr[0]&yr[0]) | (xr[0]&cr) | (yr[0]&cr)
  - bit shifts into the MSB of the internal sum register; xr and yr shift right; counter increments.
  - After WIDTH RUN edges: s <= internal sum register, c <= cr, state moves to DONE.
- Latency: start sampled at edge k; done=1 in the cycle following edge k+WIDTH, with s/c already updated.
  - Throughput is one result per WIDTH+1 cycles; back-to-back operation is possible because start is accepted during the DONE cycle.
- s and c hold their previous result throughout RUN. They change only at completion or on reset.
- Arithmetic: {c,s} = x + y + z modulo 2^(WIDTH+1), i.e. exact; no overflow is lost.
- Counter width: $clog2(WIDTH+1) bits. Its terminal value is WIDTH-1 on the last RUN edge.
- WIDTH=1: one RUN cycle; the result matches the single-bit full-adder truth table.
- Operand inputs x, y, z are don't-care outside accepted-start edges.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured alongside the operands on an accepted start.
  - sub=1: the y shift register loads ~y and the carry flop loads 1 (z is ignored), so s = x - y mod 2^WIDTH.
  - In subtract mode, c=1 means no borrow (x >= y unsigned).
  - sub=0: behaviour is identical to the undefined case.
- Undefined: no sub port; add only.

Test Plan:
- WIDTH=1, all 8 combinations of x,y,z applied one after another: each result {c,s} equals the full-adder truth table (e.g. 1,1,1 -> s=1, c=1). done fires 2 cycles after each start.
- WIDTH=8, x=8'hFF, y=8'h01, z=0: busy high for 8 cycles, done high 9 cycles after start, s=8'h00, c=1. Then x=8'h5A, y=8'h25, z=1 -> s=8'h80, c=0.
- WIDTH=8, start x=8'h0F, y=8'h01 followed by a second start (x=8'hFF, y=8'hFF) during RUN cycle 3: the second start is ignored and the result is s=8'h10, c=0.
- Start asserted continuously with x=8'h01, y=8'h01: the next operation is accepted in the DONE cycle. done pulses every 9 cycles, each pulse with s=8'h02.
- rst asserted in RUN cycle 4 of an 8'hAA+8'h55 operation: the next cycle has busy=0, done=0, s=0, c=0, and no done pulse follows.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, sub=1: x=8'h10, y=8'h01 -> s=8'h0F, c=1; x=8'h01, y=8'h02 -> s=8'hFF, c=0.
